// File: rtl/seq_divider32_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default operand width and the iteration-counter width helper.
package seq_divider32_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/seq_divider32_sub_borrow_rca.sv
// Ripple-borrow subtractor: Diff = A - B, Bout = 1 when A < B.
// Bit-for-bit mirror of the ripple-carry adder used by the adder blocks.
module sub_borrow_rca #(
    parameter int unsigned WIDTH = 33
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
);

    logic w_b;

    always_comb begin
        Diff = '0;
        w_b  = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            Diff[i] = A[i] ^ B[i] ^ w_b;
            w_b     = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & w_b);
        end
        Bout = w_b;
    end

endmodule

// File: rtl/seq_divider32.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock through a
// single shared (WIDTH+1)-bit subtractor, with a Start/Done handshake.
module seq_divider32
    import seq_divider32_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic [WIDTH:0]   w_r;
    logic [WIDTH:0]   w_diff;
    logic             w_bout;
    logic [WIDTH:0]   w_rem_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_unused_rem_msb;

    // Dividend bits are shifted out of the quotient register into the remainder.
    assign w_r        = {r_rem, r_q[WIDTH-1]};
    assign w_rem_next = w_bout ? w_r : w_diff;
    assign w_q_next   = {r_q[WIDTH-2:0], ~w_bout};
    // The restored/subtracted remainder is always below the divisor, so its MSB is 0.
    assign w_unused_rem_msb = w_rem_next[WIDTH];

    sub_borrow_rca #(
        .WIDTH(WIDTH + 1)
    ) u_sub (
        .A    (w_r),
        .B    ({1'b0, r_div}),
        .Diff (w_diff),
        .Bout (w_bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_div       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                IDLE, FINISH: begin
                    if (Start) begin
                        r_div <= Divisor;
                        r_q   <= Dividend;
                        r_rem <= '0;
                        r_cnt <= '0;
                        if (Divisor == '0) begin
                            r_quotient  <= '1;
                            r_remainder <= Dividend;
                            r_dbz       <= 1'b1;
                            r_state     <= FINISH;
                        end else begin
                            r_state <= CALC;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CALC: begin
                    r_rem <= w_rem_next[WIDTH-1:0];
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_quotient  <= w_q_next;
                        r_remainder <= w_rem_next[WIDTH-1:0];
                        r_dbz       <= 1'b0;
                        r_state     <= FINISH;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Busy      = (r_state == CALC);
    assign Done      = (r_state == FINISH);
    assign Quotient  = r_quotient;
    assign Remainder = r_remainder;
    assign DivByZero = r_dbz;

endmodule
